// File: rtl/dict_codec_pkg.sv
// Shared encodings for the dictionary codec host: engine command/response codes,
// host result status and controller state.
package dict_codec_pkg;

  localparam int DATA_W_DEF = 80;
  localparam int CODE_W_DEF = 8;

  localparam logic [1:0] CMD_NOP        = 2'b00;
  localparam logic [1:0] CMD_COMPRESS   = 2'b01;
  localparam logic [1:0] CMD_DECOMPRESS = 2'b10;
  localparam logic [1:0] CMD_INVALID    = 2'b11;

  localparam logic [1:0] RSP_IDLE      = 2'b00;
  localparam logic [1:0] RSP_COMP_OK   = 2'b01;
  localparam logic [1:0] RSP_DECOMP_OK = 2'b10;
  localparam logic [1:0] RSP_ERROR     = 2'b11;

  typedef enum logic [1:0] {
    ST_OK         = 2'b00,
    ST_ENGINE_ERR = 2'b01,
    ST_TIMEOUT    = 2'b10
  } status_e;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_RESULT
  } state_e;

  // op: 0 = compress, 1 = decompress
  function automatic logic [1:0] op_cmd(input logic op);
    return op ? CMD_DECOMPRESS : CMD_COMPRESS;
  endfunction

  function automatic logic [1:0] op_rsp(input logic op);
    return op ? RSP_DECOMP_OK : RSP_COMP_OK;
  endfunction

endpackage

// File: rtl/dict_codec_sat_counter.sv
// Saturating up-counter: holds at all-ones instead of wrapping.
module dict_codec_sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         inc,
  output logic [W-1:0] count
);

  always_ff @(posedge clk) begin
    if (reset)
      count <= '0;
    else if (inc && (count != '1))
      count <= count + W'(1);
  end

endmodule

// File: rtl/dict_codec_host.sv
// Host initiator for the dictionary engine: one request in flight, single-cycle
// command issue, response check with timeout, and saturating statistics.
module dict_codec_host
  import dict_codec_pkg::*;
#(
  parameter int DATA_W       = DATA_W_DEF,
  parameter int CODE_W       = CODE_W_DEF,
  parameter int RESP_TIMEOUT = 4,
  parameter int CNT_W        = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_op,
  input  logic [DATA_W-1:0] req_word,
  input  logic [CODE_W-1:0] req_code,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [1:0]        rsp_status,
  output logic [CODE_W-1:0] rsp_code,
  output logic [DATA_W-1:0] rsp_word,
  output logic [1:0]        chip_command,
  output logic [DATA_W-1:0] chip_data_in,
  output logic [CODE_W-1:0] chip_compressed_in,
  input  logic [CODE_W-1:0] chip_compressed_out,
  input  logic [DATA_W-1:0] chip_decompressed_out,
  input  logic [1:0]        chip_response,
  output logic [CNT_W-1:0]  cnt_compress,
  output logic [CNT_W-1:0]  cnt_decompress,
  output logic [CNT_W-1:0]  cnt_error,
  output logic              busy
);

  localparam int TW = $clog2(RESP_TIMEOUT + 1);

  state_e         state_q, state_d;
  status_e        status_d, status_q;
  logic           op_q;
  logic [TW-1:0]  tcnt_q;
  logic           wait_done;

  assign req_ready  = (state_q == S_IDLE);
  assign busy       = (state_q != S_IDLE);
  assign rsp_status = status_q;

  always_ff @(posedge clk) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // A nonzero response on the expiring sample wins over the timeout.
  always_comb begin
    state_d   = state_q;
    status_d  = ST_OK;
    wait_done = 1'b0;
    case (state_q)
      S_IDLE:   if (req_valid) state_d = S_ISSUE;
      S_ISSUE:  state_d = S_WAIT;
      S_WAIT: begin
        if (chip_response == op_rsp(op_q)) begin
          wait_done = 1'b1;
        end else if (chip_response != RSP_IDLE) begin
          wait_done = 1'b1;
          status_d  = ST_ENGINE_ERR;
        end else if (tcnt_q == TW'(RESP_TIMEOUT - 1)) begin
          wait_done = 1'b1;
          status_d  = ST_TIMEOUT;
        end
        if (wait_done) state_d = S_RESULT;
      end
      S_RESULT: if (rsp_ready) state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      op_q               <= 1'b0;
      tcnt_q             <= '0;
      chip_command       <= CMD_NOP;
      chip_data_in       <= '0;
      chip_compressed_in <= '0;
      rsp_valid          <= 1'b0;
      status_q           <= ST_OK;
      rsp_code           <= '0;
      rsp_word           <= '0;
    end else begin
      chip_command <= CMD_NOP;
      if (state_q == S_IDLE && req_valid) begin
        op_q               <= req_op;
        chip_command       <= op_cmd(req_op);
        chip_data_in       <= req_op ? '0 : req_word;
        chip_compressed_in <= req_op ? req_code : '0;
      end
      if (state_q == S_ISSUE)
        tcnt_q <= '0;
      else if (state_q == S_WAIT && chip_response == RSP_IDLE)
        tcnt_q <= tcnt_q + TW'(1);
      if (wait_done) begin
        rsp_valid <= 1'b1;
        status_q  <= status_d;
        rsp_code  <= (status_d == ST_OK && !op_q) ? chip_compressed_out : '0;
        rsp_word  <= (status_d == ST_OK &&  op_q) ? chip_decompressed_out : '0;
      end else if (state_q == S_RESULT && rsp_ready) begin
        rsp_valid <= 1'b0;
      end
    end
  end

  logic inc_comp, inc_decomp, inc_err;
  assign inc_comp   = wait_done && (status_d == ST_OK) && !op_q;
  assign inc_decomp = wait_done && (status_d == ST_OK) &&  op_q;
  assign inc_err    = wait_done && (status_d != ST_OK);

  dict_codec_sat_counter #(.W(CNT_W)) u_cnt_comp (
    .clk(clk), .reset(reset), .inc(inc_comp), .count(cnt_compress));
  dict_codec_sat_counter #(.W(CNT_W)) u_cnt_decomp (
    .clk(clk), .reset(reset), .inc(inc_decomp), .count(cnt_decompress));
  dict_codec_sat_counter #(.W(CNT_W)) u_cnt_err (
    .clk(clk), .reset(reset), .inc(inc_err), .count(cnt_error));

endmodule

// File: tb/tb_dict_codec_host.sv
// Bench for dict_codec_host: behavioural engine, directed vector table, random
// transactions against a reference model, and multi-cycle corner sequences.
module tb_dict_codec_host;

  localparam int DW = 80;
  localparam int CW = 8;
  localparam int TO = 4;
  localparam int CNTW = 2;
  localparam int CMAX = 3;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          req_valid = 1'b0, req_ready, req_op = 1'b0;
  logic [DW-1:0] req_word = '0;
  logic [CW-1:0] req_code = '0;
  logic          rsp_valid, rsp_ready = 1'b0;
  logic [1:0]    rsp_status;
  logic [CW-1:0] rsp_code;
  logic [DW-1:0] rsp_word;
  logic [1:0]    chip_command;
  logic [DW-1:0] chip_data_in;
  logic [CW-1:0] chip_compressed_in;
  logic [CW-1:0] chip_compressed_out = '0;
  logic [DW-1:0] chip_decompressed_out = '0;
  logic [1:0]    chip_response = 2'b00;
  logic [CNTW-1:0] cnt_compress, cnt_decompress, cnt_error;
  logic          busy;

  dict_codec_host #(.DATA_W(DW), .CODE_W(CW), .RESP_TIMEOUT(TO), .CNT_W(CNTW)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_word(req_word), .req_code(req_code),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_status(rsp_status),
    .rsp_code(rsp_code), .rsp_word(rsp_word),
    .chip_command(chip_command), .chip_data_in(chip_data_in),
    .chip_compressed_in(chip_compressed_in),
    .chip_compressed_out(chip_compressed_out),
    .chip_decompressed_out(chip_decompressed_out),
    .chip_response(chip_response),
    .cnt_compress(cnt_compress), .cnt_decompress(cnt_decompress), .cnt_error(cnt_error),
    .busy(busy));

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int m_comp = 0, m_decomp = 0, m_err = 0;

  // Engine behaviour for the next command: response code, extra delay, result data.
  logic [1:0]    eng_resp = 2'b00;
  int            eng_delay = 0;
  logic [CW-1:0] eng_code = '0;
  logic [DW-1:0] eng_word = '0;
  int            eng_left = 0;

  always @(posedge clk) begin
    chip_response         <= 2'b00;
    chip_compressed_out   <= CW'($urandom);
    chip_decompressed_out <= {16'($urandom), $urandom, $urandom};
    if (reset) begin
      eng_left <= 0;
    end else if (chip_command != 2'b00) begin
      if (eng_delay == 0) begin
        chip_response <= eng_resp;
        if (eng_resp != 2'b11) begin
          chip_compressed_out <= eng_code; chip_decompressed_out <= eng_word;
        end
      end else begin
        eng_left <= eng_delay;
      end
    end else if (eng_left > 0) begin
      if (eng_left == 1) begin
        chip_response <= eng_resp;
        if (eng_resp != 2'b11) begin
          chip_compressed_out <= eng_code; chip_decompressed_out <= eng_word;
        end
      end
      eng_left <= eng_left - 1;
    end
  end

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  function automatic int sat(input int n);
    return (n > CMAX) ? CMAX : n;
  endfunction

  // Reference: the response is seen on sample dly+1; it counts only if within the timeout window.
  function automatic void model(input logic op, input logic [1:0] resp, input int dly,
                                input logic [DW-1:0] ew, input logic [CW-1:0] ec,
                                output logic [1:0] st, output logic [CW-1:0] xc,
                                output logic [DW-1:0] xw, output int lat);
    st = 2'b10; xc = '0; xw = '0; lat = TO + 1;
    if (resp != 2'b00 && dly + 1 <= TO) begin
      lat = dly + 2;
      if (resp == (op ? 2'b10 : 2'b01)) begin
        st = 2'b00;
        if (op) xw = ew; else xc = ec;
      end else begin
        st = 2'b01;
      end
    end
  endfunction

  task automatic run_op(input logic op, input logic [DW-1:0] w, input logic [CW-1:0] c,
                        input logic [1:0] resp, input int dly,
                        input logic [DW-1:0] ew, input logic [CW-1:0] ec,
                        input logic [1:0] est, input logic [CW-1:0] xc,
                        input logic [DW-1:0] xw, input int lat, input int hold);
    int k;
    bit stable;
    k = 0;
    while (!req_ready && k < 20) begin @(negedge clk); k++; end
    chk("req_ready_idle", req_ready, 1);
    eng_resp = resp; eng_delay = dly; eng_code = ec; eng_word = ew;
    req_valid = 1'b1; req_op = op; req_word = w; req_code = c;
    @(negedge clk);
    req_valid = 1'b0; req_word = {16'($urandom), $urandom, $urandom}; req_code = CW'($urandom);
    chk("issue_cmd", chip_command, op ? 2'b10 : 2'b01);
    chk("issue_data", chip_data_in, op ? '0 : w);
    chk("issue_code", chip_compressed_in, op ? c : '0);
    chk("busy", busy, 1);
    k = 0;
    while (k < lat + 4) begin
      @(negedge clk); k++;
      if (k == 1) chk("cmd_one_cycle", chip_command, 2'b00);
      if (rsp_valid) break;
    end
    if (!rsp_valid) begin
      chk("rsp_valid_bound", 0, 1);
      return;
    end
    chk("latency", k, lat);
    chk("status", rsp_status, est);
    chk("rsp_code", rsp_code, xc);
    chk("rsp_word", rsp_word, xw);
    if (est == 2'b00 && !op) m_comp++;
    else if (est == 2'b00) m_decomp++;
    else m_err++;
    chk("cnt_compress", cnt_compress, sat(m_comp));
    chk("cnt_decompress", cnt_decompress, sat(m_decomp));
    chk("cnt_error", cnt_error, sat(m_err));
    if (hold > 0) begin
      stable = 1'b1;
      for (int i = 0; i < hold; i++) begin
        req_valid = 1'b1; req_op = 1'($urandom);
        @(negedge clk);
        if (!(rsp_valid && rsp_status == est && rsp_code == xc && rsp_word == xw &&
              !req_ready && chip_command == 2'b00)) stable = 1'b0;
      end
      req_valid = 1'b0;
      chk("hold_stable", stable, 1);
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    chk("rsp_drop", rsp_valid, 0);
    chk("req_ready_back", req_ready, 1);
  endtask

  typedef struct {
    logic          op;
    logic [DW-1:0] w;
    logic [CW-1:0] c;
    logic [1:0]    resp;
    int            dly;
    logic [DW-1:0] ew;
    logic [CW-1:0] ec;
    logic [1:0]    est;
    logic [CW-1:0] xc;
    logic [DW-1:0] xw;
    int            lat;
  } vec_t;

  vec_t vt[9];

  initial begin
    logic [1:0] st; logic [CW-1:0] xc; logic [DW-1:0] xw; int lat;
    logic op; logic [1:0] resp; int dly; logic [DW-1:0] w, ew; logic [CW-1:0] c, ec;
    bit never;

    vt[0] = '{1'b0, 80'h1234, 8'h00, 2'b01, 0, 80'h0, 8'h05, 2'b00, 8'h05, 80'h0, 2};
    vt[1] = '{1'b1, 80'h0, 8'h05, 2'b10, 0, 80'h1234, 8'h00, 2'b00, 8'h00, 80'h1234, 2};
    vt[2] = '{1'b0, 80'hABCD, 8'h00, 2'b11, 0, 80'h0, 8'h33, 2'b01, 8'h00, 80'h0, 2};
    vt[3] = '{1'b0, 80'h55, 8'h00, 2'b00, 0, 80'h0, 8'h00, 2'b10, 8'h00, 80'h0, 5};
    vt[4] = '{1'b0, 80'h66, 8'h00, 2'b01, 3, 80'h0, 8'h77, 2'b00, 8'h77, 80'h0, 5};
    vt[5] = '{1'b0, 80'h99, 8'h00, 2'b01, 4, 80'h0, 8'h44, 2'b10, 8'h00, 80'h0, 5};
    vt[6] = '{1'b1, 80'h0, 8'h12, 2'b01, 0, 80'hBEEF, 8'h21, 2'b01, 8'h00, 80'h0, 2};
    vt[7] = '{1'b0, 80'h7, 8'h00, 2'b10, 1, 80'hCAFE, 8'h08, 2'b01, 8'h00, 80'h0, 3};
    vt[8] = '{1'b1, 80'h0, 8'hFE, 2'b10, 2, 80'hFFEE_DDCC_BBAA_9988_7766, 8'h00,
              2'b00, 8'h00, 80'hFFEE_DDCC_BBAA_9988_7766, 4};

    // reset state
    repeat (3) @(negedge clk);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_cmd", chip_command, 0);
    chk("rst_cnts", {cnt_compress, cnt_decompress, cnt_error}, 0);
    chk("rst_rsp_data", {rsp_status, rsp_code, rsp_word}, 0);
    chk("rst_chip_in", {chip_data_in, chip_compressed_in}, 0);
    reset = 1'b0;
    @(negedge clk);
    chk("rst_req_ready", req_ready, 1);

    for (int i = 0; i < 9; i++)
      run_op(vt[i].op, vt[i].w, vt[i].c, vt[i].resp, vt[i].dly, vt[i].ew, vt[i].ec,
             vt[i].est, vt[i].xc, vt[i].xw, vt[i].lat, 0);

    // back-pressure: result held 10 cycles while a new request waits
    model(1'b0, 2'b01, 0, 80'h0, 8'h5C, st, xc, xw, lat);
    run_op(1'b0, 80'h4321, 8'h0, 2'b01, 0, 80'h0, 8'h5C, st, xc, xw, lat, 10);

    for (int i = 0; i < 40; i++) begin
      op = 1'($urandom);
      w = {16'($urandom), $urandom, $urandom};
      c = CW'($urandom);
      ew = {16'($urandom), $urandom, $urandom};
      ec = CW'($urandom);
      case ($urandom_range(0, 9))
        0:       resp = 2'b11;
        1:       resp = op ? 2'b01 : 2'b10;
        2:       resp = 2'b00;
        default: resp = op ? 2'b10 : 2'b01;
      endcase
      dly = $urandom_range(0, 5);
      model(op, resp, dly, ew, ec, st, xc, xw, lat);
      run_op(op, w, c, resp, dly, ew, ec, st, xc, xw, lat, $urandom_range(0, 2));
    end

    // reset while waiting on the engine drops the request
    eng_resp = 2'b00; eng_delay = 0;
    req_valid = 1'b1; req_op = 1'b0; req_word = 80'h77;
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    chk("wait_busy", busy, 1);
    reset = 1'b1;
    @(negedge clk);
    chk("rstw_busy", busy, 0);
    chk("rstw_rsp_valid", rsp_valid, 0);
    chk("rstw_cmd", chip_command, 0);
    chk("rstw_cnts", {cnt_compress, cnt_decompress, cnt_error}, 0);
    reset = 1'b0;
    m_comp = 0; m_decomp = 0; m_err = 0;
    never = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (rsp_valid || busy) never = 1'b1;
    end
    chk("rstw_no_result", never, 0);

    // saturation at CNT_W = 2
    for (int i = 0; i < 5; i++)
      run_op(1'b0, 80'(i + 1), 8'h0, 2'b01, 0, 80'h0, 8'(i + 9), 2'b00, 8'(i + 9), 80'h0, 2, 0);
    chk("sat_compress", cnt_compress, 2'd3);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: got running want finished");
    $fatal(1);
  end

endmodule
